// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder and its load formatter.
// The optional misalignment trap is enabled with `define DMEM_MISALIGN_TRAP_EN.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned WAIT_CNT_W = 3;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StResp = 2'b10
  } dmem_state_e;

  // Halfwords need addr[0]=0; words and the reserved size need addr[1:0]=0.
  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] addr_lo);
    logic mis;
    unique case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_load_format.sv
// Combinational load formatter: four big-endian bytes (byte at addr in [31:24]) to a
// right-justified, zero- or sign-extended 32-bit load result.
module dmem_load_format
  import dmem_pkg::*;
(
  input  logic [31:0] bytes_in,
  input  logic [1:0]  size,
  input  logic        se,
  output logic [31:0] rdata
);

  always_comb begin
    rdata = bytes_in;
    unique case (size)
      SZ_BYTE: rdata = {{24{se & bytes_in[31]}}, bytes_in[31:24]};
      SZ_HALF: rdata = {{16{se & bytes_in[31]}}, bytes_in[31:16]};
      default: rdata = bytes_in;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Big-endian byte-addressed data memory responding to the MEM-stage request with
// WAIT_CYCLES wait states. Optional trap on unaligned access: DMEM_MISALIGN_TRAP_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_rw,
  input  logic [1:0]        req_size,
  input  logic              req_se,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
`ifdef DMEM_MISALIGN_TRAP_EN
  output logic              misalign,
`endif
  output logic              stall
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [WAIT_CNT_W-1:0] WaitLoad =
      (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

  logic [7:0] mem_q [Depth];

  dmem_state_e           state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  rw_q, rw_d;
  logic [1:0]            size_q, size_d;
  logic                  se_q, se_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  mis_q, mis_d;

  logic                  load_en;
  logic                  mis_chk;
  logic [ADDR_W-1:0]     byte_addr [4];
  logic [31:0]           fetched;
  logic [31:0]           fmt_rdata;
  logic [3:0]            mem_we;
  logic [31:0]           wbytes;
  logic                  wr_go;

  // Byte addresses come from the request being latched so a zero-wait read sees them.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      byte_addr[k] = addr_d + ADDR_W'(k);
    end
    fetched = {mem_q[byte_addr[0]], mem_q[byte_addr[1]],
               mem_q[byte_addr[2]], mem_q[byte_addr[3]]};
  end

  dmem_load_format u_load_format (
    .bytes_in (fetched),
    .size     (size_d),
    .se       (se_d),
    .rdata    (fmt_rdata)
  );

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis_chk  = is_misaligned(size_d, addr_d[1:0]);
  assign misalign = resp_valid & mis_q;
`else
  assign mis_chk  = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rw_d       = rw_q;
    size_d     = size_q;
    se_d       = se_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    mis_d      = mis_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    load_en    = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          rw_d    = req_rw;
          size_d  = req_size;
          se_d    = req_se;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES > 0) begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end else begin
            state_d = StResp;
            load_en = 1'b1;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
          load_en = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        resp_valid = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (load_en) begin
      mis_d   = mis_chk;
      rdata_d = (rw_d || mis_chk) ? 32'h0 : fmt_rdata;
    end
  end

  assign stall      = ((state_q == StIdle) && req_valid) || (state_q == StWait);
  assign resp_rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      se_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      se_q    <= se_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  // Store commits on the edge leaving RESP; a reset on that edge drops it.
  always_comb begin
    wr_go  = reset && (state_q == StResp) && rw_q && !mis_q;
    wbytes = wdata_q;
    mem_we = 4'b0000;
    unique case (size_q)
      SZ_BYTE: begin
        wbytes = {wdata_q[7:0], 24'h0};
        mem_we = {3'b000, wr_go};
      end
      SZ_HALF: begin
        wbytes = {wdata_q[15:0], 16'h0};
        mem_we = {2'b00, wr_go, wr_go};
      end
      default: begin
        wbytes = wdata_q;
        mem_we = {4{wr_go}};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (mem_we[k]) begin
        mem_q[byte_addr[k]] <= wbytes[31-8*k -: 8];
      end
    end
  end

endmodule
